// File: rtl/maxpool_relu_pkg.sv
// Shared CNN definitions for the pooling stage: window geometry, channel count
// and the signed sample type carried between layers.
package maxpool_relu_pkg;
  localparam int POOL_K      = 2;
  localparam int CHANNEL_LEN = 3;
  localparam int SAMPLE_BIT  = 12;

  typedef logic signed [SAMPLE_BIT-1:0] sample_t;
endpackage

// File: rtl/maxpool_relu_if.sv
// Stream bus between conv layer 1, the pooling stage and conv layer 2.
// The producer side uses the master modport and the pooling block uses slave.
interface maxpool_relu_if
  import maxpool_relu_pkg::*;
#(
  parameter int DATA_BIT = SAMPLE_BIT
);
  logic                       valid_in;
  logic signed [DATA_BIT-1:0] conv_out_1, conv_out_2, conv_out_3;
  logic signed [DATA_BIT-1:0] max_value_1, max_value_2, max_value_3;
  logic                       valid_out;
  logic                       last_out;

  modport master (
    output valid_in, conv_out_1, conv_out_2, conv_out_3,
    input  max_value_1, max_value_2, max_value_3, valid_out, last_out
  );

  modport slave (
    input  valid_in, conv_out_1, conv_out_2, conv_out_3,
    output max_value_1, max_value_2, max_value_3, valid_out, last_out
  );
endinterface

// File: rtl/maxpool_relu_lane.sv
// One channel of the 2x2 max pool: pair holder, half-width row buffer, two
// signed comparators and the registered result. ReLU under MAXPOOL_RELU_EN.
module maxpool_lane
  import maxpool_relu_pkg::*;
#(
  parameter int WIDTH    = 24,
  parameter int DATA_BIT = SAMPLE_BIT,
  parameter int IW       = $clog2(WIDTH / POOL_K)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       accept,
  input  logic                       col_odd,
  input  logic                       row_odd,
  input  logic [IW-1:0]              idx,
  input  logic signed [DATA_BIT-1:0] sample,
  output logic signed [DATA_BIT-1:0] max_value
);
  localparam int BUF_LEN = WIDTH / POOL_K;

  logic signed [DATA_BIT-1:0] holder, pair_max, above, pooled, result;
  logic signed [DATA_BIT-1:0] rowbuf [BUF_LEN];

  assign pair_max = (holder > sample) ? holder : sample;
  assign above    = rowbuf[idx];
  assign pooled   = (pair_max > above) ? pair_max : above;

`ifdef MAXPOOL_RELU_EN
  assign result = pooled[DATA_BIT-1] ? '0 : pooled;
`else
  assign result = pooled;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                holder <= '0;
    else if (accept && !col_odd) holder <= sample;
  end

  // Row buffer is always written on the even row before the odd row reads it.
  always_ff @(posedge clk) begin
    if (accept && col_odd && !row_odd) rowbuf[idx] <= pair_max;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         max_value <= '0;
    else if (accept && col_odd && row_odd) max_value <= result;
  end
endmodule

// File: rtl/maxpool_relu.sv
// 2x2 stride-2 max pool over three channels with optional ReLU
// (define MAXPOOL_RELU_EN). Position counters and strobes are shared here.
module maxpool_relu
  import maxpool_relu_pkg::*;
#(
  parameter int WIDTH    = 24,
  parameter int HEIGHT   = 24,
  parameter int DATA_BIT = SAMPLE_BIT
) (
  input  logic          clk,
  input  logic          rst_n,
  maxpool_relu_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  localparam int RW = $clog2(HEIGHT);

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          emit, frame_end;
  logic          valid_r, last_r;
  logic [CHANNEL_LEN-1:0][DATA_BIT-1:0] conv, pooled;

  assign emit      = bus.valid_in & col[0] & row[0];
  assign frame_end = (col == CW'(WIDTH - 1)) && (row == RW'(HEIGHT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
    end else if (bus.valid_in) begin
      if (col == CW'(WIDTH - 1)) begin
        col <= '0;
        row <= (row == RW'(HEIGHT - 1)) ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r <= 1'b0;
      last_r  <= 1'b0;
    end else begin
      valid_r <= emit;
      last_r  <= emit & frame_end;
    end
  end

  assign conv[0] = bus.conv_out_1;
  assign conv[1] = bus.conv_out_2;
  assign conv[2] = bus.conv_out_3;

  for (genvar ch = 0; ch < CHANNEL_LEN; ch++) begin : g_lane
    maxpool_lane #(
      .WIDTH    (WIDTH),
      .DATA_BIT (DATA_BIT)
    ) u_lane (
      .clk       (clk),
      .rst_n     (rst_n),
      .accept    (bus.valid_in),
      .col_odd   (col[0]),
      .row_odd   (row[0]),
      .idx       (col[CW-1:1]),
      .sample    (conv[ch]),
      .max_value (pooled[ch])
    );
  end

  assign bus.max_value_1 = pooled[0];
  assign bus.max_value_2 = pooled[1];
  assign bus.max_value_3 = pooled[2];
  assign bus.valid_out   = valid_r;
  assign bus.last_out    = last_r;
endmodule

// File: tb/tb_maxpool_relu.sv
// Scoreboard bench for maxpool_relu: a frame model pushes expected windows as
// samples are driven; the monitor pops and compares on each valid_out.
module tb_maxpool_relu;
  import maxpool_relu_pkg::*;

  localparam int W  = 24;
  localparam int H  = 24;
  localparam int DB = SAMPLE_BIT;

  typedef struct {
    int v1, v2, v3;
    bit last;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  maxpool_relu_if #(.DATA_BIT(DB)) bus ();

  maxpool_relu #(.WIDTH(W), .HEIGHT(H), .DATA_BIT(DB)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int   tot = 0, bad = 0;
  int   pulses = 0, lasts = 0;
  int   pr = 0, pc = 0;
  int   mem [3][H][W];
  exp_t sb [$];
  int   held1 = 0, held2 = 0, held3 = 0;

  task automatic chk(input string tag, input int got, input int exp);
    tot++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int relu(input int x);
`ifdef MAXPOOL_RELU_EN
    return (x < 0) ? 0 : x;
`else
    return x;
`endif
  endfunction

  function automatic int win_max(input int ch);
    int m;
    m = mem[ch][pr-1][pc-1];
    if (mem[ch][pr-1][pc] > m) m = mem[ch][pr-1][pc];
    if (mem[ch][pr][pc-1] > m) m = mem[ch][pr][pc-1];
    if (mem[ch][pr][pc]   > m) m = mem[ch][pr][pc];
    return relu(m);
  endfunction

  function automatic int rnd();
    return int'($urandom_range(0, 4095)) - 2048;
  endfunction

  task automatic send(input bit v, input int a, input int b, input int c);
    exp_t e;
    bus.valid_in   = v;
    bus.conv_out_1 = sample_t'(a);
    bus.conv_out_2 = sample_t'(b);
    bus.conv_out_3 = sample_t'(c);
    if (v) begin
      mem[0][pr][pc] = a;
      mem[1][pr][pc] = b;
      mem[2][pr][pc] = c;
      if (pr % 2 == 1 && pc % 2 == 1) begin
        e.v1   = win_max(0);
        e.v2   = win_max(1);
        e.v3   = win_max(2);
        e.last = (pr == H - 1) && (pc == W - 1);
        sb.push_back(e);
      end
      if (pc == W - 1) begin
        pc = 0;
        pr = (pr == H - 1) ? 0 : pr + 1;
      end else begin
        pc++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    send(1'b0, rnd(), rnd(), rnd());
  endtask

  task automatic do_reset(input string tag);
    bus.valid_in = 1'b0;
    rst_n = 1'b0;
    #1;
    chk({tag, "_vo"},   int'(bus.valid_out), 0);
    chk({tag, "_last"}, int'(bus.last_out), 0);
    chk({tag, "_mv1"},  int'(bus.max_value_1), 0);
    chk({tag, "_mv2"},  int'(bus.max_value_2), 0);
    chk({tag, "_mv3"},  int'(bus.max_value_3), 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    pr = 0;
    pc = 0;
    sb.delete();
  endtask

  // kind 0: ramp (ch2 negated ramp), kind 1: random; stop_at<0 runs the full frame
  task automatic run_frame(input int kind, input bit gapped, input int stop_at);
    for (int n = 0; n < W * H; n++) begin
      if (n == stop_at) break;
      if (gapped && (n % 2 == 1)) begin
        idle();
        idle();
      end
      if (kind == 0) send(1'b1, n, -n, rnd());
      else           send(1'b1, rnd(), rnd(), rnd());
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      held1 = 0;
      held2 = 0;
      held3 = 0;
    end else if (bus.valid_out) begin
      pulses++;
      if (bus.last_out) lasts++;
      chk("vo_expected", int'(sb.size() > 0), 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("ch1", int'(bus.max_value_1), e.v1);
        chk("ch2", int'(bus.max_value_2), e.v2);
        chk("ch3", int'(bus.max_value_3), e.v3);
        chk("last", int'(bus.last_out), int'(e.last));
      end
      held1 = int'(bus.max_value_1);
      held2 = int'(bus.max_value_2);
      held3 = int'(bus.max_value_3);
    end else begin
      chk("last_no_vo", int'(bus.last_out), 0);
      chk("hold1", int'(bus.max_value_1), held1);
      chk("hold2", int'(bus.max_value_2), held2);
      chk("hold3", int'(bus.max_value_3), held3);
    end
  end

  initial begin
    bus.valid_in   = 1'b0;
    bus.conv_out_1 = '0;
    bus.conv_out_2 = '0;
    bus.conv_out_3 = '0;
    #2;
    do_reset("rst0");

    // Single window: ch1 {5,-3,9,2}, ch2 all-negative {-7,-2,-9,-4}
    send(1'b1, 5, -7, 100);
    send(1'b1, -3, -2, -50);
    for (int c = 2; c < W; c++) send(1'b1, 0, -100, 0);
    send(1'b1, 9, -9, 7);
    chk("win_vo_early", int'(bus.valid_out), 0);
    send(1'b1, 2, -4, -100);
    chk("win_vo", int'(bus.valid_out), 1);
    chk("win_ch1", int'(bus.max_value_1), 9);
`ifdef MAXPOOL_RELU_EN
    chk("win_ch2", int'(bus.max_value_2), 0);
`else
    chk("win_ch2", int'(bus.max_value_2), -2);
`endif
    chk("win_ch3", int'(bus.max_value_3), 100);
    idle();
    chk("win_vo_pulse", int'(bus.valid_out), 0);
    do_reset("rst_win");

    // Gapless ramp frame
    pulses = 0; lasts = 0;
    run_frame(0, 1'b0, -1);
    idle(); idle();
    chk("ramp_pulses", pulses, 144);
    chk("ramp_lasts", lasts, 1);
    chk("ramp_final", int'(bus.max_value_1), (2 * 11 + 1) * 24 + 2 * 11 + 1);

    // Same ramp with 1-0-0-1 valid pattern
    pulses = 0; lasts = 0;
    run_frame(0, 1'b1, -1);
    idle(); idle();
    chk("gap_pulses", pulses, 144);
    chk("gap_lasts", lasts, 1);

    // Reset at sample 300, then a full random frame from (0,0)
    run_frame(0, 1'b0, 300);
    idle();
    do_reset("rst_mid");
    pulses = 0; lasts = 0;
    run_frame(1, 1'b0, -1);
    idle(); idle();
    chk("mid_pulses", pulses, 144);
    chk("mid_lasts", lasts, 1);

    // Back-to-back random frames, no gap
    pulses = 0; lasts = 0;
    run_frame(1, 1'b0, -1);
    run_frame(1, 1'b0, -1);
    idle(); idle();
    chk("b2b_pulses", pulses, 288);
    chk("b2b_lasts", lasts, 2);
    chk("sb_drained", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end
endmodule
